// File: rtl/datamem_dma_pkg.sv
// rtl/datamem_dma_pkg.sv - shared types and constants for the datamem_dma transfer engine
//
// Purpose: state encoding of the engine FSM and the command op codes.
package datamem_dma_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FILL  = 3'd1,
    ST_CP_RD = 3'd2,
    ST_CP_WR = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam logic OP_FILL = 1'b0;
  localparam logic OP_COPY = 1'b1;

endpackage

// File: rtl/datamem_port_mux.sv
// rtl/datamem_port_mux.sv - core/engine select for the DataMem port with reset write gate
//
// Purpose: routes either the core's or the engine's memory request to DataMem.
// Ports:
//   rst                               reset; forces the write enable low
//   sel                               1 = engine owns the port, 0 = core passthrough
//   eng_we/eng_addr/eng_data          engine request
//   core_we/core_addr/core_data       core request
//   mem_we/mem_addr/mem_data          to DataMem
module datamem_port_mux #(
  parameter int W = 8,
  parameter int A = 8
) (
  input  logic         rst,
  input  logic         sel,
  input  logic         eng_we,
  input  logic [A-1:0] eng_addr,
  input  logic [W-1:0] eng_data,
  input  logic         core_we,
  input  logic [A-1:0] core_addr,
  input  logic [W-1:0] core_data,
  output logic         mem_we,
  output logic [A-1:0] mem_addr,
  output logic [W-1:0] mem_data
);

  // Reset only gates the strobe; address/data keep flowing so the core's
  // read path stays usable while the engine is held in reset.
  assign mem_we   = rst ? 1'b0 : (sel ? eng_we : core_we);
  assign mem_addr = sel ? eng_addr : core_addr;
  assign mem_data = sel ? eng_data : core_data;

endmodule

// File: rtl/datamem_dma.sv
// rtl/datamem_dma.sv - FILL/COPY transfer engine in front of the DataMem port
//
// Purpose: executes FILL (constant byte to N addresses) and COPY (N bytes from
// src to dst, strictly forward) while owning the memory port; otherwise the
// core port passes straight through.
// Ports:
//   clk, Reset (async, active high)
//   start, op, src_addr, dst_addr, len, fill_data   command request (sampled in IDLE)
//   busy, done                                      status; done pulses one cycle
//   core_WriteEn, core_DataAddress, core_DataIn     core memory port
//   MemWriteEn, MemDataAddress, MemDataIn           to DataMem
//   MemDataOut                                      combinational read data from DataMem
//   checksum                                        only with DATAMEM_DMA_CHECKSUM_EN
// Configuration macro: DATAMEM_DMA_CHECKSUM_EN adds the written-byte checksum.
module datamem_dma
  import datamem_dma_pkg::*;
#(
  parameter int W = 8,
  parameter int A = 8
) (
  input  logic         clk,
  input  logic         Reset,
  input  logic         start,
  input  logic         op,
  input  logic [A-1:0] src_addr,
  input  logic [A-1:0] dst_addr,
  input  logic [A:0]   len,
  input  logic [W-1:0] fill_data,
  output logic         busy,
  output logic         done,
  input  logic         core_WriteEn,
  input  logic [A-1:0] core_DataAddress,
  input  logic [W-1:0] core_DataIn,
  output logic         MemWriteEn,
  output logic [A-1:0] MemDataAddress,
  output logic [W-1:0] MemDataIn,
  input  logic [W-1:0] MemDataOut
`ifdef DATAMEM_DMA_CHECKSUM_EN
  ,
  output logic [W-1:0] checksum
`endif
);

  state_t       state, state_nxt;
  logic [A-1:0] src_q, dst_q;
  logic [A:0]   len_q, idx;
  logic [W-1:0] fill_q, hold;
  logic         last;
  logic         eng_we;
  logic [A-1:0] eng_addr;
  logic [W-1:0] eng_data;

  // idx is one bit wider than an address so len = 2^A is representable;
  // len_q >= 1 whenever this is consulted.
  assign last = (idx == len_q - (A+1)'(1));
  assign busy = (state != ST_IDLE);
  assign done = (state == ST_DONE);

  always_comb begin
    state_nxt = state;
    eng_we    = 1'b0;
    eng_addr  = dst_q + idx[A-1:0];
    eng_data  = fill_q;
    case (state)
      ST_IDLE: begin
        if (start) begin
          if (len == '0)          state_nxt = ST_DONE;
          else if (op == OP_COPY) state_nxt = ST_CP_RD;
          else                    state_nxt = ST_FILL;
        end
      end
      ST_FILL: begin
        eng_we = 1'b1;
        if (last) state_nxt = ST_DONE;
      end
      ST_CP_RD: begin
        eng_addr  = src_q + idx[A-1:0];
        state_nxt = ST_CP_WR;
      end
      ST_CP_WR: begin
        eng_we    = 1'b1;
        eng_data  = hold;
        state_nxt = last ? ST_DONE : ST_CP_RD;
      end
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      state  <= ST_IDLE;
      src_q  <= '0;
      dst_q  <= '0;
      len_q  <= '0;
      fill_q <= '0;
      idx    <= '0;
      hold   <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        ST_IDLE: begin
          if (start) begin
            src_q  <= src_addr;
            dst_q  <= dst_addr;
            len_q  <= len;
            fill_q <= fill_data;
            idx    <= '0;
          end
        end
        ST_FILL:  idx  <= idx + (A+1)'(1);
        ST_CP_RD: hold <= MemDataOut;
        ST_CP_WR: idx  <= idx + (A+1)'(1);
        default: ;
      endcase
    end
  end

`ifdef DATAMEM_DMA_CHECKSUM_EN
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      checksum <= '0;
    end else if (state == ST_IDLE && start) begin
      checksum <= '0;
    end else if (eng_we) begin
      checksum <= checksum + eng_data;
    end
  end
`endif

  // The engine keeps the port through DONE so a core write in that cycle is
  // dropped like any other write while busy.
  datamem_port_mux #(.W(W), .A(A)) u_port_mux (
    .rst       (Reset),
    .sel       (busy),
    .eng_we    (eng_we),
    .eng_addr  (eng_addr),
    .eng_data  (eng_data),
    .core_we   (core_WriteEn),
    .core_addr (core_DataAddress),
    .core_data (core_DataIn),
    .mem_we    (MemWriteEn),
    .mem_addr  (MemDataAddress),
    .mem_data  (MemDataIn)
  );

endmodule

// File: doc/datamem_dma.md
# datamem_dma

Command-driven transfer engine placed directly upstream of the 256×8 data memory (`DataMem`). It owns the memory port while a command runs and otherwise passes the core's memory port straight through. It executes two commands:
- **FILL**: write a constant byte to N consecutive addresses.
- **COPY**: read N bytes from a source range and write them to a destination range.

The core uses it for buffer initialisation and block moves without spending instruction cycles per byte.

## Interface
Parameters:
- `W`, 8, data width in bits.
- `A`, 8, address width in bits; memory depth is 2^A.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `Reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  command request; sampled only in IDLE.
- `op`  in  1  0 = FILL, 1 = COPY.
- `src_addr`  in  A  COPY source base address.
- `dst_addr`  in  A  destination base address.
- `len`  in  A+1  byte count, 0..2^A.
- `fill_data`  in  W  FILL byte.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle completion pulse.
- `core_WriteEn`, `core_DataAddress` (A), `core_DataIn` (W)  in  core memory port.
- `MemWriteEn`  out  1  to DataMem.
- `MemDataAddress`  out  A  to DataMem.
- `MemDataIn`  out  W  to DataMem.
- `MemDataOut`  in  W  combinational read data from DataMem.
- `checksum`  out  W  present only with `DATAMEM_DMA_CHECKSUM_EN`.

## Operation
- States: IDLE, FILL, CP_RD, CP_WR, DONE.
- **IDLE**
  - `Mem*` mirror the `core_*` inputs combinationally.
  - `start` latches `op`, bases, `len` and `fill_data`, and clears the byte index `i`.
  - Next state is DONE if `len`==0, else FILL or CP_RD according to `op`.
- **FILL**
  - Drives `MemWriteEn`=1, `MemDataAddress`=`dst`+`i`, `MemDataIn`=`fill_data`.
  - `i` increments each cycle.
  - Moves to DONE after the write with `i`=`len`-1.
- **CP_RD**
  - Drives `MemWriteEn`=0, `MemDataAddress`=`src`+`i`.
  - The hold register captures `MemDataOut` at the edge.
  - Always moves to CP_WR.
- **CP_WR**
  - Drives `MemWriteEn`=1, `MemDataAddress`=`dst`+`i`, `MemDataIn`=hold.
  - `i` increments.
  - Moves to DONE after the last byte, else back to CP_RD.
- **DONE**
  - `done`=1, `MemWriteEn`=0.
  - Next state is IDLE.
- Address arithmetic: base+`i` truncated to A bits, so ranges wrap past 2^A-1 to 0.
- `i` is A+1 bits wide, which allows `len`=2^A.
- Overlapping COPY proceeds strictly forward, byte by byte. A destination above the source therefore re-reads bytes already written; this is the defined behaviour.
- While `busy`:
  - `start` is ignored, with no queuing.
  - Core writes are dropped; `busy` serves as the core stall.

## Timing
Start is sampled at edge E0.
- **FILL**: byte k commits at edge E0+k+1; DONE occupies the cycle after E0+N; `busy` lasts N+1 cycles.
- **COPY**: byte k commits at edge E0+2k+2; DONE follows edge E0+2N; `busy` lasts 2N+1 cycles.
- **`len`=0**: DONE in the cycle after E0; `busy` and `done` high for 1 cycle; no write.
- `start` may be asserted again in the first IDLE cycle after DONE.
- Reset values: `busy`=0, `done`=0, `checksum`=0, state IDLE, `i`=0, hold=0.
- While `Reset` is high, `MemWriteEn` is forced to 0; address and data pass through from the core.
- Reset mid-command:
  - Aborts immediately, with no partial final write.
  - Bytes already committed keep their values.
  - A new `start` after reset release behaves normally.

## Configuration
- `DATAMEM_DMA_CHECKSUM_EN` defined:
  - `checksum` accumulates the modulo-2^W sum of every byte the engine writes in the current command.
  - It clears when `start` is accepted.
  - It is valid when `done` pulses and holds until the next accepted start.
- Undefined: the `checksum` port and its accumulator do not exist.

## Structure
- `datamem_dma_pkg` holds:
  - the state enum;
  - the op encoding constants `OP_FILL`=0 and `OP_COPY`=1.
- One sub-module, `datamem_port_mux`: the combinational core/engine select for the three `Mem*` outputs, including the reset write-gate.

## Test plan
- **FILL**: `dst`=0x10, `len`=4, `fill_data`=0x5A.
  - mem[0x10..0x13]=0x5A; mem[0x14] unchanged.
  - `done` in the 5th cycle after start.
  - `checksum`=0x68.
- **COPY**: memory preloaded with mem[a]=a^0xAA; `src`=0x00, `dst`=0x80, `len`=3.
  - mem[0x80..0x82]=0xAA, 0xAB, 0xA8.
  - `busy` for 7 cycles.
  - `checksum`=0xFD.
- **Wrap and extremes**:
  - FILL `dst`=0xFE, `len`=4, `fill_data`=0x11: addresses 0xFE, 0xFF, 0x00, 0x01 written; 0x02 untouched.
  - FILL `dst`=0, `len`=256: all 256 bytes written; `busy` for 257 cycles.
- **`len`=0**:
  - `busy`/`done` high for exactly one cycle.
  - `MemWriteEn` never asserted.
- **Arbitration**:
  - In IDLE, a core write of 0x77 to 0x33 lands in memory.
  - During FILL, a core write to 0x40 is dropped.
  - A second `start` during FILL is ignored; only the first command's bytes are written.
- **Reset mid-COPY**: assert `Reset` after 2 of 5 bytes have committed.
  - `busy`, `done` and `MemWriteEn` drop to 0 immediately.
  - The 2 written bytes persist; the remaining destinations are unchanged.
  - A subsequent FILL completes correctly.
